memory_access_sequencer: RTL and testbench
==========================================

Name: memory_access_sequencer

Overview:
- Single-port sequencer between the processor's two memory requesters, instruction fetch (stage 1) and data load/store (stage 4), and the shared word-addressable memory bus.
- Arbitrates requests and drives address, data and the r/w/hi-Z code.
- Runs the MEM_MFC completion handshake with a timeout, returns read data and an error indication, and raises Stall so the control signal generator holds its stage.

Parameters:
- TIMEOUT_CYCLES, 16, cycles waited in ACCESS for MEM_MFC before aborting (range 2..255).
- DATA_W, 32, width of address and data buses.

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- Fetch_Req  in  1  level request from fetch; held until Fetch_Ack
- Fetch_Address  in  DATA_W  PC word address
- Fetch_Ack  out  1  one-cycle completion pulse
- Fetch_Data  out  DATA_W  instruction word; valid while Fetch_Ack=1
- Data_Req  in  1  level request from memory stage; held until Data_Ack
- Data_Write  in  1  1=store, 0=load
- Data_Address  in  DATA_W  RZ word address
- Data_Write_Value  in  DATA_W  RM store value
- Data_Ack  out  1  one-cycle completion pulse
- Data_Read_Value  out  DATA_W  load result; valid while Data_Ack=1
- Access_Error  out  1  high together with the Ack of a failed access
- Stall  out  1  a request is pending and not yet acknowledged
- MEM_Address  out  DATA_W  bus address
- MEM_Data_In  out  DATA_W  bus write data
- MEM_r_w_z_z  out  2  00=read, 01=write, 10=hi-Z
- MEM_Data_Out  in  DATA_W  bus read data
- MEM_MFC  in  1  memory function complete
- MEM_ERROR  in  1  address not assigned
- Stat_Fetches, Stat_Loads_Stores, Stat_Errors  out  16 each  statistics (see Optional Feature)

Behaviour:
- State machine: IDLE, ACCESS, RESP.
- Reset (synchronous; takes effect at the next edge from any state, including mid-ACCESS):
  - state=IDLE, timeout counter=0, Fetch_Ack=Data_Ack=Access_Error=0.
  - MEM_r_w_z_z=10, MEM_Address=0, MEM_Data_In=0, Fetch_Data=Data_Read_Value=0.
  - No Ack is issued for an access aborted by reset.
- IDLE:
  - Bus is 10.
  - If Data_Req=1, grant data, because data belongs to the older instruction and fixed priority avoids deadlock when stage 4 and the next fetch overlap.
  - Else if Fetch_Req=1, grant fetch.
  - On grant, register owner, address, write flag and write value; go to ACCESS. Requests are sampled in IDLE only.
- ACCESS:
  - Drives the registered address; MEM_r_w_z_z=01 for a store, 00 for a load or fetch. MEM_Data_In carries the write value for stores, 0 otherwise.
  - Counter increments each cycle.
  - MEM_MFC=1: capture MEM_Data_Out into the owner's data register, set error=MEM_ERROR, go to RESP.
  - MEM_ERROR=1 with MEM_MFC=0: abort immediately with error=1.
  - Counter reaches TIMEOUT_CYCLES-1 without MEM_MFC: abort with error=1, data=0.
- RESP:
  - Bus back to 10.
  - Exactly one cycle with the owner's Ack=1, Access_Error=error; then go to IDLE and clear the counter.
  - The requester must deassert Req in the cycle after Ack. A Req still high in IDLE is treated as a new access.
- Latency: Req sampled in IDLE at cycle n → ACCESS at n+1. MFC seen at n+1+k → Ack at n+2+k. Minimum 2 cycles.
- Stall = (Fetch_Req & ~Fetch_Ack) | (Data_Req & ~Data_Ack); combinational.
- Simultaneous Fetch_Req and Data_Req: data first. Fetch is granted in the IDLE cycle after Data_Ack, so it waits at least 3 cycles.
- Both Acks are never high in the same cycle.

Optional Feature:
- Macro ACCESS_STATS_EN.
- Defined:
  - Stat_Fetches counts fetch Acks; Stat_Loads_Stores counts data Acks; Stat_Errors counts Acks with Access_Error=1.
  - All three saturate at 16'hFFFF, clear on Reset and update on the RESP edge.
- Undefined: all three ports exist and are tied to 0; no counter logic.

Test Plan:
- Fetch_Req=1, Fetch_Address=0x10, MFC 1 cycle after ACCESS entry, MEM_Data_Out=0xDEADBEEF → MEM_r_w_z_z=00, MEM_Address=0x10; Fetch_Ack pulse with Fetch_Data=0xDEADBEEF 3 cycles after Req; Stall high 3 cycles.
- Fetch_Req and Data_Req (store, addr 0x40, value 0x1234) raised together → store first (r_w=01, MEM_Data_In=0x1234), Data_Ack; fetch granted next IDLE; Fetch_Ack later, never same cycle.
- Load to 0x7F, MEM_MFC never asserted, TIMEOUT_CYCLES=16 → Data_Ack with Access_Error=1, Data_Read_Value=0 after 16 ACCESS cycles; bus returns to 10.
- MEM_ERROR=1, MEM_MFC=0 on 2nd ACCESS cycle → immediate RESP, Ack with Access_Error=1.
- Reset pulsed on 3rd ACCESS cycle of a store → next cycle IDLE, MEM_r_w_z_z=10, no Ack, all outputs 0.
- ACCESS_STATS_EN defined: 3 fetches, 2 stores, 1 timeout → Stat_Fetches=3, Stat_Loads_Stores=3, Stat_Errors=1; undefined: all 0.

Source files
------------

// File: rtl/memory_access_sequencer.sv
// rtl/memory_access_sequencer.sv - fetch/data arbiter and MEM_MFC handshake sequencer
// Optional statistics counters enabled by ACCESS_STATS_EN.
module memory_access_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_W         = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Fetch_Req,
    input  logic [DATA_W-1:0] Fetch_Address,
    output logic              Fetch_Ack,
    output logic [DATA_W-1:0] Fetch_Data,
    input  logic              Data_Req,
    input  logic              Data_Write,
    input  logic [DATA_W-1:0] Data_Address,
    input  logic [DATA_W-1:0] Data_Write_Value,
    output logic              Data_Ack,
    output logic [DATA_W-1:0] Data_Read_Value,
    output logic              Access_Error,
    output logic              Stall,
    output logic [DATA_W-1:0] MEM_Address,
    output logic [DATA_W-1:0] MEM_Data_In,
    output logic [1:0]        MEM_r_w_z_z,
    input  logic [DATA_W-1:0] MEM_Data_Out,
    input  logic              MEM_MFC,
    input  logic              MEM_ERROR,
    output logic [15:0]       Stat_Fetches,
    output logic [15:0]       Stat_Loads_Stores,
    output logic [15:0]       Stat_Errors
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_next;
    logic              owner_data;
    logic              write_q;
    logic              error_q;
    logic [DATA_W-1:0] address_q;
    logic [DATA_W-1:0] write_value_q;
    logic [DATA_W-1:0] fetch_data_q;
    logic [DATA_W-1:0] read_data_q;
    logic [7:0]        count_q;
    logic              timed_out;

    assign timed_out = (count_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= IDLE;
            owner_data    <= 1'b0;
            write_q       <= 1'b0;
            error_q       <= 1'b0;
            address_q     <= '0;
            write_value_q <= '0;
            fetch_data_q  <= '0;
            read_data_q   <= '0;
            count_q       <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    count_q <= '0;
                    error_q <= 1'b0;
                    // Data wins ties: it belongs to the older instruction.
                    if (Data_Req) begin
                        owner_data    <= 1'b1;
                        address_q     <= Data_Address;
                        write_q       <= Data_Write;
                        write_value_q <= Data_Write_Value;
                    end else if (Fetch_Req) begin
                        owner_data    <= 1'b0;
                        address_q     <= Fetch_Address;
                        write_q       <= 1'b0;
                        write_value_q <= '0;
                    end
                end
                ACCESS: begin
                    count_q <= count_q + 8'd1;
                    if (MEM_MFC) begin
                        error_q <= MEM_ERROR;
                        if (owner_data) read_data_q  <= MEM_Data_Out;
                        else            fetch_data_q <= MEM_Data_Out;
                    end else if (MEM_ERROR || timed_out) begin
                        error_q <= 1'b1;
                        if (owner_data) read_data_q  <= '0;
                        else            fetch_data_q <= '0;
                    end
                end
                RESP:    count_q <= '0;
                default: count_q <= '0;
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        MEM_r_w_z_z  = 2'b10;
        MEM_Address  = '0;
        MEM_Data_In  = '0;
        Fetch_Ack    = 1'b0;
        Data_Ack     = 1'b0;
        Access_Error = 1'b0;
        case (state)
            IDLE: begin
                if (Data_Req || Fetch_Req) state_next = ACCESS;
            end
            ACCESS: begin
                MEM_Address = address_q;
                MEM_r_w_z_z = write_q ? 2'b01 : 2'b00;
                MEM_Data_In = write_q ? write_value_q : '0;
                if (MEM_MFC || MEM_ERROR || timed_out) state_next = RESP;
            end
            RESP: begin
                Fetch_Ack    = ~owner_data;
                Data_Ack     = owner_data;
                Access_Error = error_q;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign Fetch_Data      = fetch_data_q;
    assign Data_Read_Value = read_data_q;
    assign Stall           = (Fetch_Req & ~Fetch_Ack) | (Data_Req & ~Data_Ack);

`ifdef ACCESS_STATS_EN
    logic [15:0] stat_fetches_q, stat_data_q, stat_errors_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stat_fetches_q <= '0;
            stat_data_q    <= '0;
            stat_errors_q  <= '0;
        end else if (state == RESP) begin
            if (!owner_data && stat_fetches_q != 16'hFFFF) stat_fetches_q <= stat_fetches_q + 16'd1;
            if (owner_data && stat_data_q != 16'hFFFF)     stat_data_q    <= stat_data_q + 16'd1;
            if (error_q && stat_errors_q != 16'hFFFF)      stat_errors_q  <= stat_errors_q + 16'd1;
        end
    end

    assign Stat_Fetches      = stat_fetches_q;
    assign Stat_Loads_Stores = stat_data_q;
    assign Stat_Errors       = stat_errors_q;
`else
    assign Stat_Fetches      = 16'h0;
    assign Stat_Loads_Stores = 16'h0;
    assign Stat_Errors       = 16'h0;
`endif
endmodule

// File: tb/tb_memory_access_sequencer.sv
// tb/tb_memory_access_sequencer.sv - randomized self-checking bench for memory_access_sequencer
`timescale 1ns/1ps
module tb_memory_access_sequencer;
    localparam int T  = 16;
    localparam int DW = 32;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Fetch_Req, Data_Req, Data_Write;
    logic [DW-1:0] Fetch_Address, Data_Address, Data_Write_Value;
    logic          Fetch_Ack, Data_Ack, Access_Error, Stall;
    logic [DW-1:0] Fetch_Data, Data_Read_Value;
    logic [DW-1:0] MEM_Address, MEM_Data_In, MEM_Data_Out;
    logic [1:0]    MEM_r_w_z_z;
    logic          MEM_MFC, MEM_ERROR;
    logic [15:0]   Stat_Fetches, Stat_Loads_Stores, Stat_Errors;

    int checks = 0;
    int errors = 0;
    int n_fetch = 0, n_data = 0, n_err = 0;

    memory_access_sequencer #(.TIMEOUT_CYCLES(T), .DATA_W(DW)) dut (
        .Clock(Clock), .Reset(Reset),
        .Fetch_Req(Fetch_Req), .Fetch_Address(Fetch_Address),
        .Fetch_Ack(Fetch_Ack), .Fetch_Data(Fetch_Data),
        .Data_Req(Data_Req), .Data_Write(Data_Write), .Data_Address(Data_Address),
        .Data_Write_Value(Data_Write_Value), .Data_Ack(Data_Ack),
        .Data_Read_Value(Data_Read_Value), .Access_Error(Access_Error), .Stall(Stall),
        .MEM_Address(MEM_Address), .MEM_Data_In(MEM_Data_In), .MEM_r_w_z_z(MEM_r_w_z_z),
        .MEM_Data_Out(MEM_Data_Out), .MEM_MFC(MEM_MFC), .MEM_ERROR(MEM_ERROR),
        .Stat_Fetches(Stat_Fetches), .Stat_Loads_Stores(Stat_Loads_Stores),
        .Stat_Errors(Stat_Errors)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // One complete request as seen by a requester and a memory: the access ends at the
    // first of MFC, a lone MEM_ERROR, or the timeout, and the Ack follows one cycle later.
    task automatic do_access(input bit is_data, input bit wr, input logic [DW-1:0] addr,
                             input logic [DW-1:0] wval, input int mfc_at, input int err_at,
                             input logic [DW-1:0] rdata, input string tag);
        int e;
        bit exp_err;
        logic [DW-1:0] exp_data;
        logic [5:0] got_v, exp_v;
        e = T;
        if (mfc_at > 0 && mfc_at < e) e = mfc_at;
        if (err_at > 0 && err_at < e) e = err_at;
        if (mfc_at == e) begin exp_err = (err_at == e); exp_data = rdata; end
        else begin exp_err = 1'b1; exp_data = '0; end
        Fetch_Address = is_data ? $urandom : addr;
        Data_Address = is_data ? addr : $urandom;
        Data_Write = wr;
        Data_Write_Value = wval;
        for (int c = 0; c <= e + 2; c++) begin
            bit in_acc, ackc;
            Fetch_Req = !is_data && (c <= e + 1);
            Data_Req = is_data && (c <= e + 1);
            MEM_MFC = (c >= 1 && c == mfc_at);
            MEM_ERROR = (c >= 1 && c == err_at);
            MEM_Data_Out = (c == mfc_at) ? rdata : $urandom;
            #1;
            in_acc = (c >= 1 && c <= e);
            ackc = (c == e + 1);
            got_v = {Stall, MEM_r_w_z_z, Fetch_Ack, Data_Ack, Access_Error};
            exp_v = {c <= e, in_acc ? {1'b0, wr} : 2'b10, !is_data && ackc, is_data && ackc,
                     ackc && exp_err};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s ctl c=%0d: got stall/rwzz/fack/dack/err=%b need %b", tag, c, got_v, exp_v);
            end
            checks++;
            if (MEM_Address !== (in_acc ? addr : '0) || MEM_Data_In !== ((in_acc && wr) ? wval : '0)) begin
                errors++;
                $display("FAIL %s bus c=%0d: got addr=%h din=%h need addr=%h din=%h", tag, c,
                         MEM_Address, MEM_Data_In, in_acc ? addr : '0, (in_acc && wr) ? wval : '0);
            end
            if (ackc) begin
                checks++;
                if ((is_data ? Data_Read_Value : Fetch_Data) !== exp_data) begin
                    errors++;
                    $display("FAIL %s data: got %h need %h", tag,
                             is_data ? Data_Read_Value : Fetch_Data, exp_data);
                end
            end
            @(posedge Clock);
            #1;
        end
        MEM_MFC = 1'b0;
        MEM_ERROR = 1'b0;
        if (is_data) n_data++; else n_fetch++;
        if (exp_err) n_err++;
    endtask

    task automatic check_stats(input string tag);
        logic [47:0] exp_s;
`ifdef ACCESS_STATS_EN
        exp_s = {16'(n_fetch), 16'(n_data), 16'(n_err)};
`else
        exp_s = '0;
`endif
        checks++;
        if ({Stat_Fetches, Stat_Loads_Stores, Stat_Errors} !== exp_s) begin
            errors++;
            $display("FAIL %s stats: got %h need %h", tag,
                     {Stat_Fetches, Stat_Loads_Stores, Stat_Errors}, exp_s);
        end
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        n_fetch = 0; n_data = 0; n_err = 0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Fetch_Req = 0; Data_Req = 0; Data_Write = 0;
        Fetch_Address = 0; Data_Address = 0; Data_Write_Value = 0;
        MEM_Data_Out = 0; MEM_MFC = 0; MEM_ERROR = 0;
        repeat (3) tick();
        Reset = 1'b0;
        checks++;
        if ({Fetch_Ack, Data_Ack, Access_Error, Stall, MEM_r_w_z_z} !== 6'b000010 ||
            MEM_Address !== '0 || MEM_Data_In !== '0 || Fetch_Data !== '0 || Data_Read_Value !== '0) begin
            errors++;
            $display("FAIL reset: got acks/err/stall/rwzz=%b addr=%h din=%h fd=%h dr=%h need 000010 and zeros",
                     {Fetch_Ack, Data_Ack, Access_Error, Stall, MEM_r_w_z_z}, MEM_Address,
                     MEM_Data_In, Fetch_Data, Data_Read_Value);
        end
        check_stats("reset");
    endtask

    task automatic test_fetch_basic();
        do_access(0, 0, 32'h10, 0, 2, 0, 32'hDEADBEEF, "fetch_basic");
        do_access(1, 0, 32'h24, 0, 1, 0, 32'hCAFE0001, "load_min");
    endtask

    task automatic test_priority();
        int d, f, last;
        logic [DW-1:0] faddr, fdata;
        logic [5:0] got_v, exp_v;
        d = $urandom_range(1, 4);
        f = $urandom_range(1, 4);
        faddr = $urandom;
        fdata = $urandom;
        last = d + 4 + f;
        Fetch_Address = faddr;
        Data_Address = 32'h40;
        Data_Write = 1'b1;
        Data_Write_Value = 32'h1234;
        for (int c = 0; c <= last; c++) begin
            bit dacc, facc;
            Data_Req = (c <= d + 1);
            Fetch_Req = (c <= d + 3 + f);
            MEM_MFC = (c == d) || (c == d + 2 + f);
            MEM_ERROR = 1'b0;
            MEM_Data_Out = (c == d + 2 + f) ? fdata : $urandom;
            #1;
            dacc = (c >= 1 && c <= d);
            facc = (c >= d + 3 && c <= d + 2 + f);
            got_v = {Stall, MEM_r_w_z_z, Fetch_Ack, Data_Ack, Access_Error};
            exp_v = {c <= d + 2 + f, dacc ? 2'b01 : (facc ? 2'b00 : 2'b10),
                     c == d + 3 + f, c == d + 1, 1'b0};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL priority ctl c=%0d: got %b need %b", c, got_v, exp_v);
            end
            checks++;
            if (MEM_Address !== (dacc ? 32'h40 : (facc ? faddr : '0)) ||
                MEM_Data_In !== (dacc ? 32'h1234 : '0)) begin
                errors++;
                $display("FAIL priority bus c=%0d: got addr=%h din=%h", c, MEM_Address, MEM_Data_In);
            end
            if (c == d + 3 + f) begin
                checks++;
                if (Fetch_Data !== fdata) begin
                    errors++;
                    $display("FAIL priority fetch data: got %h need %h", Fetch_Data, fdata);
                end
            end
            tick();
        end
        MEM_MFC = 1'b0;
        n_fetch++;
        n_data++;
    endtask

    task automatic test_timeout();
        do_access(1, 0, 32'h7F, 0, 0, 0, 32'h0, "timeout");
    endtask

    task automatic test_mem_error();
        do_access(1, 0, 32'h99, 0, 0, 2, 32'h0, "mem_error_load");
        do_access(0, 0, 32'h55, 0, 3, 3, 32'hA5A5A5A5, "mfc_with_error");
    endtask

    task automatic test_reset_mid_access();
        Data_Address = 32'h300;
        Data_Write = 1'b1;
        Data_Write_Value = 32'hBEEF;
        Data_Req = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        Reset = 1'b1;
        Data_Req = 1'b0;
        #1;
        checks++;
        if (MEM_r_w_z_z !== 2'b01 || MEM_Address !== 32'h300) begin
            errors++;
            $display("FAIL reset_mid pre: got rwzz=%b addr=%h need 01 and 300", MEM_r_w_z_z, MEM_Address);
        end
        tick();
        Reset = 1'b0;
        n_fetch = 0; n_data = 0; n_err = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({Fetch_Ack, Data_Ack, Access_Error, Stall, MEM_r_w_z_z} !== 6'b000010 ||
                MEM_Address !== '0 || MEM_Data_In !== '0 || Data_Read_Value !== '0 || Fetch_Data !== '0) begin
                errors++;
                $display("FAIL reset_mid c=%0d: got ctl=%b addr=%h din=%h dr=%h need 000010 and zeros", c,
                         {Fetch_Ack, Data_Ack, Access_Error, Stall, MEM_r_w_z_z}, MEM_Address,
                         MEM_Data_In, Data_Read_Value);
            end
            tick();
        end
        check_stats("reset_mid");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            bit is_data, wr;
            int mfc_at, err_at;
            is_data = $urandom_range(0, 1);
            wr = is_data && $urandom_range(0, 1);
            mfc_at = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            do_access(is_data, wr, $urandom, $urandom, mfc_at, err_at, $urandom, "random");
        end
        check_stats("random");
    endtask

    task automatic test_stats();
        pulse_reset();
        for (int i = 0; i < 3; i++) do_access(0, 0, 32'h100 + i, 0, 1 + i, 0, $urandom, "stats_fetch");
        for (int i = 0; i < 2; i++) do_access(1, 1, 32'h200 + i, $urandom, 2, 0, $urandom, "stats_store");
        do_access(1, 0, 32'h7F, 0, 0, 0, 0, "stats_timeout");
        check_stats("stats");
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_priority();
        test_timeout();
        test_mem_error();
        check_stats("after_basic");
        test_reset_mid_access();
        test_random();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
